// File: rtl/vinstru_capture_pkg.sv
// Shared types and sizes for the virtual-instrument capture stage.
package vinstru_capture_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned LEN_W      = 12;
  localparam int unsigned CNT_W      = LEN_W + 1;
  localparam int unsigned WORD_W     = 2 * SAMPLE_W;
  localparam int unsigned WE_W       = WORD_W / 8;
  localparam int unsigned BRAM_WORDS = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic              en;
    logic [WE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
  } bram_wr_t;

  // A zero length selects the whole buffer.
  function automatic logic [CNT_W-1:0] len_to_target(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(BRAM_WORDS) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/vinstru_capture_if.sv
// Control, sample-stream and BRAM-port bundle of the capture stage.
interface vinstru_capture_if;
  import vinstru_capture_pkg::*;

  logic                run;
  logic                trig_en;
  logic                trigger;
  logic [LEN_W-1:0]    capture_len;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;

  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    words_written;
  logic                bram_en;
  logic [WE_W-1:0]     bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [WORD_W-1:0]   bram_din;

  modport master (
    output run, trig_en, trigger, capture_len, sample_valid, sample_data,
    input  busy, done, words_written, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  run, trig_en, trigger, capture_len, sample_valid, sample_data,
    output busy, done, words_written, bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/vinstru_capture.sv
// Packs 16-bit samples pairwise into 32-bit words and writes them to the capture BRAM.
// Run/trigger control arms the capture; done holds until run is dropped.
module vinstru_capture
  import vinstru_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  vinstru_capture_if.slave cap_if
);

  cap_state_e          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [SAMPLE_W-1:0] half_q, half_d;
  logic                half_vld_q, half_vld_d;
  bram_wr_t            bram_q, bram_d;

  logic                arm_c;
  logic                accept_c;
  logic                wr_c;
  logic                wr_last_c;

  // A sample in the trigger cycle counts as the first sample of the run.
  assign arm_c     = (state_q == ST_IDLE) && cap_if.run;
  assign accept_c  = cap_if.sample_valid && cap_if.run &&
                     ((state_q == ST_CAPTURE) ||
                      ((state_q == ST_ARMED) && cap_if.trigger));
  assign wr_c      = accept_c && half_vld_q;
  assign wr_last_c = wr_c && ((words_q + CNT_W'(1)) == target_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_if.run) begin
          state_d = cap_if.trig_en ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (!cap_if.run) begin
          state_d = ST_IDLE;
        end else if (cap_if.trigger) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!cap_if.run) begin
          state_d = ST_IDLE;
        end else if (wr_last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!cap_if.run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status, pair latch and BRAM write port; en/we pulse only on write cycles.
  always_comb begin
    busy_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d     = (state_d == ST_DONE);
    words_d    = words_q;
    target_d   = target_q;
    half_d     = half_q;
    half_vld_d = half_vld_q;
    bram_d     = bram_q;
    bram_d.en  = 1'b0;
    bram_d.we  = '0;

    if (arm_c) begin
      words_d    = '0;
      target_d   = len_to_target(cap_if.capture_len);
      half_vld_d = 1'b0;
    end else if (wr_c) begin
      bram_d.en   = 1'b1;
      bram_d.we   = '1;
      bram_d.addr = {words_q[ADDR_W-3:0], 2'b00};
      bram_d.din  = {cap_if.sample_data, half_q};
      words_d     = words_q + CNT_W'(1);
      half_vld_d  = 1'b0;
    end else if (accept_c) begin
      half_d     = cap_if.sample_data;
      half_vld_d = 1'b1;
    end else if (!cap_if.run) begin
      half_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      words_q    <= '0;
      target_q   <= CNT_W'(BRAM_WORDS);
      half_q     <= '0;
      half_vld_q <= 1'b0;
      bram_q     <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      words_q    <= words_d;
      target_q   <= target_d;
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
      bram_q     <= bram_d;
    end
  end

  assign cap_if.busy          = busy_q;
  assign cap_if.done          = done_q;
  assign cap_if.words_written = words_q;
  assign cap_if.bram_en       = bram_q.en;
  assign cap_if.bram_we       = bram_q.we;
  assign cap_if.bram_addr     = bram_q.addr;
  assign cap_if.bram_din      = bram_q.din;

endmodule

// File: tb/tb_vinstru_capture.sv
// Bench for vinstru_capture: directed and random stimulus against a sample-count reference model.
module tb_vinstru_capture;
  import vinstru_capture_pkg::*;

  logic clk;
  logic reset;
  vinstru_capture_if cif ();

  vinstru_capture u_dut (
    .clk    (clk),
    .reset  (reset),
    .cap_if (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 done.
  int          m_phase;
  int          m_nacc;
  int          m_words;
  int          m_target;
  logic [15:0] m_low;
  logic        m_en;
  int          m_addr;
  logic [31:0] m_din;

  bram_wr_t    wr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_nacc  = 0;
    m_words = 0;
    m_en    = 1'b0;
    m_addr  = 0;
    m_din   = '0;
  endtask

  task automatic compare_all();
    chk("busy",      32'(cif.busy),          32'((m_phase == 1) || (m_phase == 2)));
    chk("done",      32'(cif.done),          32'(m_phase == 3));
    chk("words",     32'(cif.words_written), 32'(m_words));
    chk("bram_en",   32'(cif.bram_en),       32'(m_en));
    chk("bram_we",   32'(cif.bram_we),       m_en ? 32'hF : 32'h0);
    chk("bram_addr", 32'(cif.bram_addr),     32'(m_addr));
    chk("bram_din",  cif.bram_din,           m_din);
  endtask

  // One clock: model consumes this cycle's inputs, DUT result is sampled 1 time unit after the edge.
  task automatic step();
    logic     acc;
    bram_wr_t w;
    acc  = 1'b0;
    m_en = 1'b0;
    case (m_phase)
      0: if (cif.run) begin
           m_words  = 0;
           m_nacc   = 0;
           m_target = (cif.capture_len == '0) ? 4096 : int'(cif.capture_len);
           m_phase  = cif.trig_en ? 1 : 2;
         end
      1: if (!cif.run) m_phase = 0;
         else if (cif.trigger) begin
           m_phase = 2;
           acc     = cif.sample_valid;
         end
      2: if (!cif.run) m_phase = 0;
         else acc = cif.sample_valid;
      default: if (!cif.run) m_phase = 0;
    endcase
    if (acc) begin
      if (m_nacc % 2 == 0) begin
        m_low = cif.sample_data;
      end else begin
        m_en   = 1'b1;
        m_addr = 4 * m_words;
        m_din  = {cif.sample_data, m_low};
        m_words++;
        if (m_words == m_target) m_phase = 3;
      end
      m_nacc++;
    end
    @(posedge clk);
    #1;
    compare_all();
    if (cif.bram_en) begin
      w.en   = cif.bram_en;
      w.we   = cif.bram_we;
      w.addr = cif.bram_addr;
      w.din  = cif.bram_din;
      wr_q.push_back(w);
    end
  endtask

  task automatic idle_cycles(input int n);
    cif.run          = 1'b0;
    cif.trigger      = 1'b0;
    cif.sample_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic arm(input logic ten, input logic [11:0] len);
    idle_cycles(2);
    wr_q.delete();
    cif.trig_en      = ten;
    cif.capture_len  = len;
    cif.run          = 1'b1;
    cif.sample_valid = 1'b0;
    step();
  endtask

  task automatic sample(input logic [15:0] d);
    cif.sample_valid = 1'b1;
    cif.sample_data  = d;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    cif.run          = 1'b0;
    cif.trig_en      = 1'b0;
    cif.trigger      = 1'b0;
    cif.capture_len  = '0;
    cif.sample_valid = 1'b0;
    cif.sample_data  = '0;
    reset            = 1'b1;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Back-to-back pair packing, length 2.
    arm(1'b0, 12'd2);
    for (int i = 1; i <= 4; i++) sample(16'(i));
    for (int i = 0; i < 3; i++) sample(16'h7777);
    chk("s1_nwr",  32'(wr_q.size()), 32'd2);
    chk("s1_din0", wr_q[0].din, 32'h0002_0001);
    chk("s1_adr0", 32'(wr_q[0].addr), 32'h0);
    chk("s1_din1", wr_q[1].din, 32'h0004_0003);
    chk("s1_adr1", 32'(wr_q[1].addr), 32'h4);
    chk("s1_done", 32'(cif.done), 32'd1);

    // Triggered start: the trigger-cycle sample becomes the first low half.
    arm(1'b1, 12'd4);
    for (int i = 0; i < int'($urandom_range(3, 10)); i++) sample(16'($urandom));
    chk("s2_prewr", 32'(wr_q.size()), 32'd0);
    cif.trigger = 1'b1;
    sample(16'h0A0A);
    cif.trigger = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cif.trigger = (i == 3);
      sample(16'($urandom));
    end
    cif.trigger = 1'b0;
    chk("s2_lo",  32'(wr_q[0].din[15:0]), 32'h0A0A);
    chk("s2_nwr", 32'(wr_q.size()), 32'd4);

    // Full-depth capture.
    arm(1'b0, 12'd0);
    for (int c = 0; c < 9000 && !cif.done; c++) sample(16'($urandom));
    for (int c = 0; c < 20; c++) sample(16'($urandom));
    chk("s3_nwr",  32'(wr_q.size()), 32'd4096);
    chk("s3_last", 32'(wr_q[$].addr), 32'h3FFC);
    chk("s3_done", 32'(cif.done), 32'd1);

    // Abort after three samples; the odd sample in the abort cycle is dropped.
    arm(1'b0, 12'd4);
    for (int i = 0; i < 3; i++) sample(16'($urandom));
    cif.run = 1'b0;
    sample(16'hDEAD);
    idle_cycles(3);
    chk("s4_nwr",   32'(wr_q.size()), 32'd1);
    chk("s4_words", 32'(cif.words_written), 32'd1);
    chk("s4_done",  32'(cif.done), 32'd0);

    // Gapped stream, one valid every third cycle.
    arm(1'b0, 12'd3);
    for (int c = 0; c < 60 && !cif.done; c++) begin
      cif.sample_valid = (c % 3 == 0);
      cif.sample_data  = 16'($urandom);
      step();
    end
    cif.sample_valid = 1'b0;
    repeat (4) step();
    chk("s5_nwr", 32'(wr_q.size()), 32'd3);

    // Random runs with mid-run length changes, stray triggers and run drops.
    for (int s = 0; s < 30; s++) begin
      arm(1'($urandom_range(0, 1)), 12'($urandom_range(1, 12)));
      for (int c = 0; c < 60; c++) begin
        cif.sample_valid = ($urandom_range(0, 3) != 0);
        cif.sample_data  = 16'($urandom);
        cif.trigger      = ($urandom_range(0, 7) == 0);
        cif.capture_len  = 12'($urandom_range(1, 4095));
        cif.run          = ($urandom_range(0, 49) != 0);
        step();
      end
    end

    // Reset asserted while an odd sample is presented.
    arm(1'b0, 12'd8);
    sample(16'h1111);
    cif.sample_data = 16'h2222;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    wr_q.delete();
    cif.sample_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) sample(16'($urandom));
    chk("s7_adr0", 32'(wr_q[0].addr), 32'h0);
    chk("s7_nwr",  32'(wr_q.size()), 32'd2);

    // Reset while a write is on the BRAM port.
    for (int i = 0; i < 6 && !m_en; i++) sample(16'($urandom));
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("s7_en_rst", 32'(cif.bram_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vinstru_capture.md
Name: vinstru_capture

Overview:
- Downstream capture stage of the virtual instrument.
- Consumes the 16-bit sample stream produced by the pulse/noise generator and packs samples pairwise into 32-bit words.
- Writes the words into the PCIe-visible capture BRAM through its native BRAM port.
- Run/trigger/done control comes from regfile bits; software reads the buffer after done.

Parameters:
- SAMPLE_W, 16, width of one input sample
- ADDR_W, 14, BRAM byte-address width (4096 words)
- LEN_W, 12, width of capture_len (words)

Ports:
- clk  in  1  single clock for all logic (generator and BRAM port domain)
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 arms/continues capture, 0 aborts and returns to idle
- trig_en  in  1  1 = wait for trigger after arming; 0 = start immediately
- trigger  in  1  single-cycle start strobe from generator (pulse start)
- capture_len  in  LEN_W  words to capture; 0 means full depth (4096)
- sample_valid  in  1  sample_data valid this cycle (no backpressure)
- sample_data  in  SAMPLE_W  two's-complement sample
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- words_written  out  LEN_W+1  words committed this run
- bram_en  out  1  BRAM enable
- bram_we  out  4  byte write enables
- bram_addr  out  ADDR_W  byte address, word aligned ([1:0]=0)
- bram_din  out  32  write data

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, words_written=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, half-word latch empty.
- States:
  - IDLE: outputs quiet. run=1 -> ARMED if trig_en=1, else CAPTURE. Entry clears words_written, address and pair latch. target = capture_len, or 4096 when capture_len=0, sampled at this transition.
  - ARMED: run=0 -> IDLE. trigger=1 -> CAPTURE; a sample valid in the trigger cycle is captured as the first sample.
  - CAPTURE: each valid sample is accepted. Even-index sample is latched as the low half. Odd-index sample registers a write in the next cycle: bram_en=1, bram_we=4'hF, bram_din={odd,even}, bram_addr=4*words_written. words_written increments in that same cycle. Write latency is 1 cycle after the odd sample.
  - CAPTURE exit: when the write bringing words_written to target is issued, state=DONE in that same cycle. Samples arriving after this are ignored.
  - DONE: done=1 while run=1. run=0 -> IDLE next cycle, done=0. words_written holds until the next arm.
- bram_en and bram_we are high only in write cycles, otherwise 0. bram_din and bram_addr hold their last value.
- run=0 in ARMED or CAPTURE aborts next cycle. An odd sample in the abort cycle is not written. A pending half-word is discarded. words_written keeps the count written so far.
- trigger outside ARMED is ignored. Re-trigger during CAPTURE has no effect.
- Address wrap does not occur: target ≤ 4096 words, so the maximum address is 0x3FFC.
- capture_len changes during a run have no effect.
- reset mid-write: the write is dropped; all outputs return to reset values immediately.

Decomposition:
- Shared package vinstru_pkg: capture state enum (IDLE, ARMED, CAPTURE, DONE), BRAM_WORDS=4096, SAMPLE_W.
- Optional sub-module vinstru_pack2: 16->32 pair packer with valid-out. It is small enough to inline; keep it inline unless reused by a second capture channel.

Test Plan:
- Reset, run=1, trig_en=0, capture_len=2, samples 0x0001..0x0004 back-to-back -> writes 0x00020001 @0x0000 and 0x00040003 @0x0004, we=4'hF. done=1 in the second write cycle; words_written=2.
- trig_en=1, run=1, samples streaming, trigger with sample 0x0A0A -> first word low half=0x0A0A. No writes occur before the trigger.
- capture_len=0 with continuous valid -> exactly 4096 writes; last at 0x3FFC; done=1. Further samples cause no bram_en.
- Drop run after 3 samples with capture_len=4 -> one write only, state IDLE, done=0, words_written=1.
- Gapped stream (valid every 3rd cycle), capture_len=3 -> writes spaced per pairs, each 1 cycle after its odd sample; done after the 3rd write.
- Assert reset during CAPTURE on an odd-sample cycle -> bram_en=0 immediately, all outputs 0. Re-arm restarts at address 0.
